// File: rtl/and_reduce_sched_pkg.sv
// Shared definitions for the AND-reduce scheduler.
//   state_t        : scheduler FSM encoding (IDLE=0, RUN=1, DONE=2)
//   REQ_BR/REQ_ALU : requester IDs (branch zero-detect, ALU flag logic)
//   beat_w()       : counter width needed to index WIDTH/8 slices
package and_reduce_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_BR  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/and_reduce_sched_and8.sv
// 8-input AND reduction: the single shared datapath resource.
//   a : 8-bit slice in
//   y : &a
module and8_gate (
  input  logic [7:0] a,
  output logic       y
);
  assign y = &a;
endmodule

// File: rtl/and_reduce_sched_arb.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_valid  : per-requester valid
//   update     : a grant was taken this cycle; remember it
//   grant_vld  : some requester is valid
//   grant      : granted requester (combinational)
// last_grant resets to REQ_ALU so requester 0 wins the first contention.
module rr_arbiter2
  import and_reduce_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       update,
  output logic       grant_vld,
  output logic       grant
);
  logic last_grant;

  assign grant_vld = |req_valid;

  always_comb begin
    grant = REQ_BR;
    case (req_valid)
      2'b01:   grant = REQ_BR;
      2'b10:   grant = REQ_ALU;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_BR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= REQ_ALU;
    else if (update) last_grant <= grant;
  end
endmodule

// File: rtl/and_reduce_sched.sv
// Shared-resource scheduler for the 8-input AND reduction tree.
//   clk, rst_n       : clock, async active-low reset
//   req_valid/ready  : per-requester handshake (ready only in IDLE, to grantee)
//   reqN_operand     : WIDTH-bit operand, sampled at accept
//   reqN_inv         : 1 = zero-detect (operand inverted first)
//   resp_valid       : one-cycle result pulse (DONE state), no backpressure
//   resp_id          : owner of the result
//   resp_result      : reduction result
//   busy             : RUN or DONE
// One 8-bit slice per cycle goes through and8_gate; a zero slice ends early.
module and_reduce_sched
  import and_reduce_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_operand,
  input  logic [WIDTH-1:0] req1_operand,
  input  logic             req0_inv,
  input  logic             req1_inv,
  output logic             resp_valid,
  output logic             resp_id,
  output logic             resp_result,
  output logic             busy
);
  localparam int BEATS = WIDTH / 8;
  localparam int BW    = beat_w(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  state_t           state, nxt;
  logic [WIDTH-1:0] op_reg, op_sel;
  logic [BW-1:0]    beat;
  logic             id_reg, acc;
  logic             idle, accept, grant, grant_vld, and8_out;
  logic [7:0]       slice;

  assign idle   = (state == IDLE);
  assign accept = idle & grant_vld;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .update    (accept),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  assign req_ready[0] = accept & (grant == REQ_BR);
  assign req_ready[1] = accept & (grant == REQ_ALU);

  // Inversion is folded in at capture so the run loop is a plain AND-reduce.
  assign op_sel = grant ? (req1_operand ^ {WIDTH{req1_inv}})
                        : (req0_operand ^ {WIDTH{req0_inv}});

  assign slice = op_reg[{beat, 3'b000} +: 8];

  and8_gate u_and8 (
    .a (slice),
    .y (and8_out)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = RUN;
      RUN:     if (!and8_out || beat == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_reg <= '0;
      id_reg <= 1'b0;
      acc    <= 1'b0;
      beat   <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_reg <= op_sel;
        id_reg <= grant;
        acc    <= 1'b1;
        beat   <= '0;
      end else if (state == RUN) begin
        acc  <= acc & and8_out;
        beat <= beat + 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so they are glitch-free.
  assign resp_valid  = (state == DONE);
  assign resp_result = resp_valid & acc;
  assign resp_id     = resp_valid & id_reg;
  assign busy        = ~idle;
endmodule

// File: tb/tb_and_reduce_sched.sv
// Scoreboard bench for and_reduce_sched: stimulus pushes expected
// {id, result, response cycle}; a negedge monitor pops and compares.
module tb_and_reduce_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_operand = '0, req1_operand = '0;
  logic        req0_inv = 1'b0, req1_inv = 1'b0;
  logic        resp_valid, resp_id, resp_result, busy;

  and_reduce_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_operand(req0_operand), .req1_operand(req1_operand),
    .req0_inv(req0_inv), .req1_inv(req1_inv),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic id;
    logic res;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("ready_low_busy", {30'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        chk("valid_implies_busy", {31'd0, busy}, 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
          chk("resp_result", {31'd0, resp_result}, {31'd0, e.res});
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issue one request; waits (bounded) for grant. lat<0: no expectation.
  task automatic issue(input logic id, input logic [31:0] op, input logic inv,
                       input logic res, input int lat);
    bit got = 0;
    @(negedge clk);
    if (id) begin req1_operand = op; req1_inv = inv; end
    else    begin req0_operand = op; req0_inv = inv; end
    req_valid[id] = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[id]) begin got = 1; break; end
      @(negedge clk); #1;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    else if (lat >= 0) q.push_back('{id: id, res: res, cyc: cyc + 1 + lat});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int prev_acc;
    #2;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_result", {31'd0, resp_result}, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Idle stability.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid | busy | (|req_ready)) chk("idle_stable", {29'd0, resp_valid, busy, |req_ready}, 32'd0);
    end
    chk("idle_end_busy", {31'd0, busy}, 32'd0);

    // Directed vectors: id, operand, inv, expected result, latency.
    issue(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 4); drain();
    issue(1'b1, 32'h0000_0000, 1'b1, 1'b1, 4); drain();
    issue(1'b1, 32'h0001_0000, 1'b1, 1'b0, 3); drain();
    issue(1'b0, 32'hFFFF_00FF, 1'b0, 1'b0, 2); drain();
    issue(1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1); drain();
    issue(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 4); drain();

    // Contention: last grant was requester 1, so grants go 0,1,0,1.
    @(negedge clk);
    req0_operand = 32'hFFFF_FFFF; req0_inv = 1'b0;
    req1_operand = 32'h0000_0000; req1_inv = 1'b1;
    req_valid = 2'b11;
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      bit got = 0;
      #1;
      for (int i = 0; i < 50; i++) begin
        if (|req_ready) begin got = 1; break; end
        @(negedge clk); #1;
      end
      if (!got) begin
        chk("contend_timeout", 32'd0, 32'd1);
        break;
      end
      chk("contend_grant", {30'd0, req_ready}, (k % 2) ? 32'd2 : 32'd1);
      if (k > 0) chk("contend_spacing", cyc + 1 - prev_acc, 32'd6);
      prev_acc = cyc + 1;
      q.push_back('{id: req_ready[1], res: 1'b1, cyc: cyc + 1 + 4});
      @(posedge clk); #1;
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    req_valid = 2'b00;
    drain();

    // Reset during RUN beat 2: no response may appear.
    issue(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, -1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    issue(1'b1, 32'h0000_0000, 1'b1, 1'b1, 4); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end
endmodule
